// File: rtl/cpu_pkg.sv
// Shared opcode, state and error definitions for the two-phase CPU control unit.
package cpu_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b010000;
  localparam logic [5:0] OP_JZ   = 6'b010001;
  localparam logic [5:0] OP_JNZ  = 6'b010010;
  localparam logic [5:0] OP_CALL = 6'b010011;
  localparam logic [5:0] OP_RET  = 6'b010100;
  localparam logic [5:0] OP_HALT = 6'b011111;
  localparam logic [3:0] LI_PREFIX  = 4'b0000;
  localparam logic       ALU_PREFIX = 1'b1;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_HALTED} state_t;

  typedef struct packed {
    logic       pc_en;
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op_alu;
    logic       push;
    logic       pop;
    logic       s_stack;
  } strobes_t;

  // Quiescent datapath controls: nothing written, PC mux parked on PC+1.
  function automatic strobes_t idle_strobes();
    strobes_t s;
    s         = '0;
    s.s_inc   = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the sequencer and the datapath.
interface cpu_sequencer_if;
  logic       start;
  logic [5:0] opcode;
  logic       z;
  logic       pc_en;
  logic       s_inc;
  logic       s_inm;
  logic       we3;
  logic       wez;
  logic [2:0] op_alu;
  logic       push_signal;
  logic       pop_signal;
  logic       s_stack;
  logic       busy;
  logic       halted;
  logic [1:0] err;

  modport master (
    input  start, opcode, z,
    output pc_en, s_inc, s_inm, we3, wez, op_alu,
           push_signal, pop_signal, s_stack, busy, halted, err
  );

  modport slave (
    output start, opcode, z,
    input  pc_en, s_inc, s_inm, we3, wez, op_alu,
           push_signal, pop_signal, s_stack, busy, halted, err
  );
endinterface

// File: rtl/cpu_decode.sv
// Combinational EXEC-phase decoder: opcode/z plus stack occupancy -> datapath strobes.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       sp_full,
  input  logic       sp_empty,
  output strobes_t   str,
  output logic       illegal,
  output logic       halt_req,
  output logic [1:0] err_code
);

  always_comb begin
    str       = idle_strobes();
    str.pc_en = 1'b1;
    illegal   = 1'b0;
    halt_req  = 1'b0;
    err_code  = ERR_NONE;
    casez (opcode)
      6'b1?????: begin
        str.op_alu = opcode[4:2];
        str.we3    = 1'b1;
        str.wez    = 1'b1;
      end
      6'b0000??: begin
        str.we3   = 1'b1;
        str.s_inm = 1'b1;
      end
      OP_NOP: ;
      OP_J:   str.s_inc = 1'b0;
      OP_JZ:  str.s_inc = ~z;
      OP_JNZ: str.s_inc = z;
      // Stack boundary faults suppress the push/pop so the stack contents survive.
      OP_CALL: begin
        if (sp_full) begin
          str.pc_en = 1'b0;
          err_code  = ERR_OVF;
        end else begin
          str.push  = 1'b1;
          str.s_inc = 1'b0;
        end
      end
      OP_RET: begin
        if (sp_empty) begin
          str.pc_en = 1'b0;
          err_code  = ERR_UNF;
        end else begin
          str.pop     = 1'b1;
          str.s_stack = 1'b1;
        end
      end
      OP_HALT: halt_req = 1'b1;
      default: begin
        str      = idle_strobes();
        illegal  = 1'b1;
        err_code = ERR_ILL;
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// FETCH/EXEC sequencer with start/halt control, return-stack occupancy tracking
// and sticky error reporting.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter bit AUTOSTART   = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  cpu_sequencer_if.master bus
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam state_t RST_STATE = AUTOSTART ? ST_FETCH : ST_IDLE;

  state_t          state_q, state_d;
  logic [SP_W-1:0] sp_cnt_q, sp_cnt_d;
  logic [1:0]      err_q, err_d;

  strobes_t   dec_str, str;
  logic       dec_illegal, dec_halt;
  logic [1:0] dec_err;

  cpu_decode u_decode (
    .opcode   (bus.opcode),
    .z        (bus.z),
    .sp_full  (sp_cnt_q == SP_W'(STACK_DEPTH)),
    .sp_empty (sp_cnt_q == '0),
    .str      (dec_str),
    .illegal  (dec_illegal),
    .halt_req (dec_halt),
    .err_code (dec_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RST_STATE;
      sp_cnt_q <= '0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      sp_cnt_q <= sp_cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sp_cnt_d = sp_cnt_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (dec_str.push)     sp_cnt_d = sp_cnt_q + 1'b1;
        else if (dec_str.pop) sp_cnt_d = sp_cnt_q - 1'b1;
        if (dec_illegal || dec_err != ERR_NONE) begin
          err_d   = dec_err;
          state_d = ST_HALTED;
        end else if (dec_halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_FETCH;
        end
      end
      // Once an error is latched only reset leaves HALTED.
      ST_HALTED: if (bus.start && err_q == ERR_NONE) state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    str = idle_strobes();
    if (state_q == ST_EXEC) str = dec_str;
  end

  assign bus.pc_en       = str.pc_en;
  assign bus.s_inc       = str.s_inc;
  assign bus.s_inm       = str.s_inm;
  assign bus.we3         = str.we3;
  assign bus.wez         = str.wez;
  assign bus.op_alu      = str.op_alu;
  assign bus.push_signal = str.push;
  assign bus.pop_signal  = str.pop;
  assign bus.s_stack     = str.s_stack;
  assign bus.busy        = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign bus.halted      = (state_q == ST_HALTED);
  assign bus.err         = err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed checks of the sequencer: decode, stack limits, halt/resume, errors, reset.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  cpu_sequencer_if bus ();

  cpu_sequencer #(.STACK_DEPTH(8), .AUTOSTART(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges, leaving the FSM in IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // IDLE/HALTED -> FETCH using a one-cycle start pulse.
  task automatic kick();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // From FETCH: present opcode and advance into EXEC.
  task automatic to_exec(input logic [5:0] op, input logic zz);
    bus.opcode = op;
    bus.z      = zz;
    step();
  endtask

  int pushes;

  initial begin
    bus.start  = 1'b0;
    bus.opcode = 6'b0;
    bus.z      = 1'b0;
    #12;
    chk("rst_busy",   bus.busy,   0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_pc_en",  bus.pc_en,  0);
    chk("rst_s_inc",  bus.s_inc,  1);
    chk("rst_op_alu", bus.op_alu, 0);
    chk("rst_err",    bus.err,    0);
    reset = 1'b0;
    step();
    chk("idle_wait_busy", bus.busy, 0);

    // ALU op 001
    bus.opcode = 6'b100100;
    kick();
    chk("fetch_busy", bus.busy, 1);
    chk("fetch_we3",  bus.we3,  0);
    chk("fetch_wez",  bus.wez,  0);
    chk("fetch_pc_en", bus.pc_en, 0);
    bus.start = 1'b1;  // start while busy must be ignored
    to_exec(6'b100100, 1'b0);
    chk("alu_we3",    bus.we3,    1);
    chk("alu_wez",    bus.wez,    1);
    chk("alu_op",     bus.op_alu, 3'b001);
    chk("alu_pc_en",  bus.pc_en,  1);
    chk("alu_s_inc",  bus.s_inc,  1);
    chk("alu_s_inm",  bus.s_inm,  0);
    chk("alu_busy",   bus.busy,   1);
    step();
    bus.start = 1'b0;
    chk("alu_next_fetch", bus.busy & ~bus.pc_en, 1);

    to_exec(OP_JZ, 1'b1);
    chk("jz1_s_inc", bus.s_inc, 0);
    chk("jz1_pc_en", bus.pc_en, 1);
    step();
    to_exec(OP_JZ, 1'b0);
    chk("jz0_s_inc", bus.s_inc, 1);
    step();
    to_exec(6'b000010, 1'b0);
    chk("li_we3",   bus.we3,   1);
    chk("li_s_inm", bus.s_inm, 1);
    chk("li_wez",   bus.wez,   0);
    step();
    to_exec(OP_NOP, 1'b0);
    chk("nop_pc_en", bus.pc_en, 1);
    chk("nop_we3",   bus.we3,   0);
    step();
    to_exec(OP_J, 1'b1);
    chk("j_s_inc", bus.s_inc, 0);
    step();
    to_exec(OP_JNZ, 1'b0);
    chk("jnz0_s_inc", bus.s_inc, 0);
    step();
    to_exec(6'b111000, 1'b0);
    chk("alu_op110", bus.op_alu, 3'b110);
    step();

    // Fill the return stack, then overflow it.
    pushes = 0;
    for (int i = 0; i < 8; i++) begin
      to_exec(OP_CALL, 1'b0);
      if (bus.push_signal === 1'b1 && bus.s_inc === 1'b0 && bus.pc_en === 1'b1) pushes++;
      step();
    end
    chk("call_pushes", pushes, 8);
    chk("call_sp_cnt", dut.sp_cnt_q, 8);
    to_exec(OP_CALL, 1'b0);
    chk("ovf_push",  bus.push_signal, 0);
    chk("ovf_pc_en", bus.pc_en,       0);
    step();
    chk("ovf_halted", bus.halted, 1);
    chk("ovf_err",    bus.err,    ERR_OVF);
    chk("ovf_sp_cnt", dut.sp_cnt_q, 8);
    kick();
    chk("ovf_start_ignored", bus.halted, 1);

    // RET on empty stack.
    do_reset();
    kick();
    to_exec(OP_RET, 1'b0);
    chk("unf_pop",   bus.pop_signal, 0);
    chk("unf_pc_en", bus.pc_en,      0);
    step();
    chk("unf_halted", bus.halted, 1);
    chk("unf_err",    bus.err,    ERR_UNF);

    // Balanced CALL/RET.
    do_reset();
    kick();
    to_exec(OP_CALL, 1'b0);
    step();
    to_exec(OP_RET, 1'b0);
    chk("ret_pop",     bus.pop_signal,  1);
    chk("ret_s_stack", bus.s_stack,     1);
    chk("ret_no_push", bus.push_signal, 0);
    step();
    chk("ret_sp_cnt", dut.sp_cnt_q, 0);
    chk("ret_err",    bus.err,      0);

    // HALT, resume, then illegal opcode.
    to_exec(OP_HALT, 1'b0);
    chk("halt_pc_en", bus.pc_en, 1);
    chk("halt_s_inc", bus.s_inc, 1);
    step();
    chk("halt_halted", bus.halted, 1);
    chk("halt_err",    bus.err,    0);
    step();
    chk("halt_hold", bus.halted, 1);
    kick();
    chk("resume_busy",   bus.busy,   1);
    chk("resume_halted", bus.halted, 0);
    to_exec(6'b000101, 1'b0);
    chk("ill_pc_en", bus.pc_en, 0);
    chk("ill_we3",   bus.we3,   0);
    step();
    chk("ill_halted", bus.halted, 1);
    chk("ill_err",    bus.err,    ERR_ILL);

    // Reset in the middle of a CALL's EXEC cycle.
    do_reset();
    kick();
    to_exec(OP_CALL, 1'b0);
    chk("mid_push_pre", bus.push_signal, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_push",  bus.push_signal, 0);
    chk("mid_pc_en", bus.pc_en,       0);
    chk("mid_busy",  bus.busy,        0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("mid_sp_cnt", dut.sp_cnt_q, 0);
    chk("mid_state",  dut.state_q,  ST_IDLE);
    chk("mid_halted", bus.halted,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  always @(negedge clk)
    if (bus.push_signal === 1'b1 && bus.pop_signal === 1'b1)
      chk("push_pop_excl", 1, 0);

endmodule
